comma_detect: RTL
=================

COMMA_DETECT -- requirements
Module: comma_detect

Interface
REQ-001 SHALL have port BitCLK  input  1  serial bit clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port Serial  input  1  recovered serial bit, one bit per BitCLK cycle; first bit of a symbol is bit a (symbol LSB).
REQ-004 SHALL have port CommaDetEn  input  1  detector enable; low forces HUNT and suppresses Comma.
REQ-005 SHALL have port Comma  output  1  alignment pulse to the SIPO stage; high in the cycle in which the last bit (j) of an accepted comma is on Serial.
REQ-006 SHALL have port Aligned  output  1  registered lock indicator, high only in LOCKED.
REQ-007 SHALL have parameter LOCK_CNT, default 3, meaning consecutive in-phase commas required to lock.
REQ-008 SHALL have parameter LOSS_CNT, default 4, meaning consecutive off-phase commas in LOCKED that force loss of lock.

Function
REQ-009 SHALL keep a 9-bit history H of the previous Serial bits: H[8] from one cycle ago, H[0] from nine cycles ago.
REQ-010 SHALL form window W[9:0] = {Serial, H[8:0]}, W[0] = bit a; match = (W == 10'h17C or W == 10'h283), i.e. K28.5 RD- and RD+.
REQ-011 SHALL gate match with a fill counter: match is ignored until 9 bits have been shifted in since reset or since CommaDetEn rose.
REQ-012 SHALL keep phase counter P (0..9): P <= 0 on an accepted comma; otherwise P wraps 9->0 and increments by 1 each cycle.
REQ-013 SHALL classify a match as in-phase when P == 9, and as off-phase otherwise.
REQ-014 SHALL implement the FSM states HUNT, VERIFY and LOCKED; the reset state is HUNT.
REQ-015 In HUNT, any match SHALL assert Comma, set P <= 0, set good count <= 1, and move to VERIFY (or to LOCKED if LOCK_CNT == 1).
REQ-016 In VERIFY, an in-phase match SHALL assert Comma and increment the good count; when the count reaches LOCK_CNT, the FSM SHALL move to LOCKED.
REQ-017 In VERIFY, an off-phase match SHALL assert Comma, set P <= 0, set good count <= 1, and remain in VERIFY (re-align to the new position).
REQ-018 In LOCKED, an in-phase match SHALL assert Comma and clear the miss count.
REQ-019 In LOCKED, an off-phase match SHALL NOT assert Comma, SHALL NOT reset P, and SHALL increment the miss count; at LOSS_CNT, the FSM SHALL go to HUNT and clear Aligned.
REQ-020 Cycles without a match SHALL NOT change the good count or the miss count.
REQ-021 Comma SHALL be a Mealy output, combinational from Serial and registered state only, with no further combinational inputs; all other outputs SHALL be registered.
REQ-022 Aligned SHALL rise on the edge that enters LOCKED and fall on the edge that leaves it.
REQ-023 CommaDetEn low SHALL force Comma = 0 and, on the next edge, set state = HUNT and clear the fill counter, good count and miss count; H SHALL keep shifting.
REQ-024 The good count and the miss count SHALL saturate and never wrap.

Reset
REQ-025 Reset low SHALL immediately clear H, P, the fill counter, the good count and the miss count, set state = HUNT, and drive Comma = 0 and Aligned = 0.
REQ-026 Reset asserted mid-symbol or while LOCKED SHALL discard all alignment; after release, REQ-011 fill applies again.
REQ-027 Reset release SHALL be treated as synchronous to BitCLK by the integrator; the block SHALL need no internal reset synchronizer.

Verification
REQ-028 The bench SHALL cover: after reset, CommaDetEn=1, send 10'h17C LSB-first -> Comma high exactly in the bit-j cycle, state VERIFY, Aligned=0.
REQ-029 The bench SHALL cover: three K28.5 symbols spaced exactly 10 bits apart (alternating 17C/283) -> Comma on each; Aligned rises on the edge after the third j bit.
REQ-030 The bench SHALL cover: in VERIFY, a second comma 13 bits after the first -> Comma asserted, P restarts, good count = 1, Aligned stays 0.
REQ-031 The bench SHALL cover: LOCKED, then 4 off-phase commas with no in-phase comma between them -> no Comma pulses, Aligned falls after the 4th; with 3 off-phase commas then 1 in-phase comma -> lock held.
REQ-032 The bench SHALL cover: a comma pattern completing within the first 8 bits after reset -> no Comma; Reset pulsed low while LOCKED -> Aligned=0 asynchronously, HUNT.
REQ-033 The bench SHALL cover: CommaDetEn low during a valid comma -> Comma=0, Aligned=0 next edge; re-enable, then 10 fill bits and a comma -> normal detection.

Source files
------------

// File: rtl/comma_detect.sv
// K28.5 comma detector for a serial 8b/10b receiver.
// Watches the recovered bit stream for either running-disparity form of
// K28.5, pulses Comma on the bit-j cycle of an accepted comma, and tracks
// symbol lock through a HUNT / VERIFY / LOCKED state machine.
//
// Comma is a Mealy output: it depends on the current Serial bit, the
// registered state and the detector enable. Everything else is registered.
// DbgState exposes the FSM state (0 = HUNT, 1 = VERIFY, 2 = LOCKED).
module comma_detect #(
    parameter int LOCK_CNT = 3,  // consecutive in-phase commas needed to lock
    parameter int LOSS_CNT = 4   // consecutive off-phase commas that drop lock
) (
    input  logic       BitCLK,
    input  logic       Reset,       // asynchronous, active low
    input  logic       Serial,
    input  logic       CommaDetEn,
    output logic       Comma,
    output logic       Aligned,
    output logic [1:0] DbgState
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(LOSS_CNT + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);
    localparam logic [MW-1:0] MISS_MAX = MW'(LOSS_CNT);

    // Registered state
    logic [8:0]    hist_q;     // hist_q[8] = previous bit, hist_q[0] = nine bits ago
    logic [3:0]    phase_q,  phase_d;
    logic [3:0]    fill_q,   fill_d;
    logic [GW-1:0] good_q,   good_d;
    logic [MW-1:0] miss_q,   miss_d;
    logic [1:0]    state_q,  state_d;
    logic          aligned_q;

    // Window and match qualification
    logic [9:0] window;
    logic       is_k28_5;
    logic       match;
    logic       in_phase;
    logic       accept;
    logic [GW-1:0] good_inc;
    logic [MW-1:0] miss_inc;

    assign window   = {Serial, hist_q};          // window[0] is bit a
    assign is_k28_5 = (window == 10'h17C) || (window == 10'h283);
    // A match only counts once nine fresh bits sit in the history.
    assign match    = CommaDetEn && (fill_q == 4'd9) && is_k28_5;
    assign in_phase = (phase_q == 4'd9);
    // Off-phase commas are ignored while locked; everywhere else a match re-aligns.
    assign accept   = match && ((state_q != LOCKED) || in_phase);

    assign Comma    = accept;
    assign Aligned  = aligned_q;
    assign DbgState = state_q;

    // Next-state logic for the lock FSM, the fill counter and the saturating counters
    always_comb begin
        state_d  = state_q;
        good_d   = good_q;
        miss_d   = miss_q;
        fill_d   = fill_q;
        good_inc = (good_q == GOOD_MAX) ? good_q : good_q + 1'b1;
        miss_inc = (miss_q == MISS_MAX) ? miss_q : miss_q + 1'b1;

        if (!CommaDetEn) begin
            state_d = HUNT;
            good_d  = '0;
            miss_d  = '0;
            fill_d  = '0;
        end else begin
            fill_d = (fill_q == 4'd9) ? fill_q : fill_q + 4'd1;
            if (match) begin
                case (state_q)
                    HUNT: begin
                        good_d = GW'(1);
                        if (LOCK_CNT <= 1) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end else begin
                            state_d = VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (in_phase) begin
                            good_d = good_inc;
                            if (good_inc == GOOD_MAX) begin
                                state_d = LOCKED;
                                miss_d  = '0;
                            end
                        end else begin
                            // Comma at a new position: restart verification there.
                            good_d = GW'(1);
                        end
                    end
                    LOCKED: begin
                        if (in_phase) begin
                            miss_d = '0;
                        end else begin
                            miss_d = miss_inc;
                            if (miss_inc == MISS_MAX) begin
                                state_d = HUNT;
                            end
                        end
                    end
                    default: state_d = HUNT;
                endcase
            end
        end
    end

    // Symbol phase: zero on the bit after an accepted comma, otherwise count 0..9
    always_comb begin
        phase_d = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
        if (accept) begin
            phase_d = 4'd0;
        end
    end

    // State registers; history keeps shifting regardless of the enable
    always_ff @(posedge BitCLK or negedge Reset) begin
        if (!Reset) begin
            hist_q    <= '0;
            phase_q   <= '0;
            fill_q    <= '0;
            good_q    <= '0;
            miss_q    <= '0;
            state_q   <= HUNT;
            aligned_q <= 1'b0;
        end else begin
            hist_q    <= {Serial, hist_q[8:1]};
            phase_q   <= phase_d;
            fill_q    <= fill_d;
            good_q    <= good_d;
            miss_q    <= miss_d;
            state_q   <= state_d;
            aligned_q <= (state_d == LOCKED);
        end
    end

endmodule
